// File: rtl/seg_pkg.sv
// ============================================================================
// Module      : seg_pkg
// Description : Active-low {g,f,e,d,c,b,a} hex patterns and scan FSM states.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package seg_pkg;

  localparam logic [6:0] SEG_OFF   = 7'h7F;

  localparam logic [6:0] SEG_HEX_0 = 7'h40;
  localparam logic [6:0] SEG_HEX_1 = 7'h79;
  localparam logic [6:0] SEG_HEX_2 = 7'h24;
  localparam logic [6:0] SEG_HEX_3 = 7'h30;
  localparam logic [6:0] SEG_HEX_4 = 7'h19;
  localparam logic [6:0] SEG_HEX_5 = 7'h12;
  localparam logic [6:0] SEG_HEX_6 = 7'h02;
  localparam logic [6:0] SEG_HEX_7 = 7'h78;
  localparam logic [6:0] SEG_HEX_8 = 7'h00;
  localparam logic [6:0] SEG_HEX_9 = 7'h10;
  localparam logic [6:0] SEG_HEX_A = 7'h08;
  localparam logic [6:0] SEG_HEX_B = 7'h03;
  localparam logic [6:0] SEG_HEX_C = 7'h46;
  localparam logic [6:0] SEG_HEX_D = 7'h21;
  localparam logic [6:0] SEG_HEX_E = 7'h06;
  localparam logic [6:0] SEG_HEX_F = 7'h0E;

  typedef enum logic [0:0] {
    ON  = 1'b0,
    OFF = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/hex_to_seg.sv
// ============================================================================
// Module      : hex_to_seg
// Description : Combinational 4-bit hex to active-low seven-segment decoder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hex_to_seg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  import seg_pkg::*;

  always_comb begin
    seg_o = SEG_OFF;
    case (hex_i)
      4'h0: seg_o = SEG_HEX_0;
      4'h1: seg_o = SEG_HEX_1;
      4'h2: seg_o = SEG_HEX_2;
      4'h3: seg_o = SEG_HEX_3;
      4'h4: seg_o = SEG_HEX_4;
      4'h5: seg_o = SEG_HEX_5;
      4'h6: seg_o = SEG_HEX_6;
      4'h7: seg_o = SEG_HEX_7;
      4'h8: seg_o = SEG_HEX_8;
      4'h9: seg_o = SEG_HEX_9;
      4'hA: seg_o = SEG_HEX_A;
      4'hB: seg_o = SEG_HEX_B;
      4'hC: seg_o = SEG_HEX_C;
      4'hD: seg_o = SEG_HEX_D;
      4'hE: seg_o = SEG_HEX_E;
      4'hF: seg_o = SEG_HEX_F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seven_seg_scan.sv
// ============================================================================
// Module      : seven_seg_scan
// Description : Multiplexed hex display scanner with anti-ghost gap and
//               frame-synchronous double-buffered load.
//               Option macro: SEVEN_SEG_LEADING_BLANK_EN (blank leading zeros).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module seven_seg_scan #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int GAP    = 500
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DIGITS*4-1:0] in,
  input  logic                load,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   an,
  output logic                frame_done
);

  import seg_pkg::*;

  localparam int CNT_MAX = (DIV > GAP) ? DIV : GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DIGITS*4-1:0]   shown_q, shown_d;
  logic [DIGITS*4-1:0]   pending_q, pending_d;
  logic                  pend_flag_q, pend_flag_d;
  logic                  frame_done_q, frame_done_d;

  logic                  w_commit;
  logic [3:0]            w_nibble;
  logic [6:0]            w_dec;
  logic                  w_digit_blank;

  // Frame boundary: last gap cycle after the final digit, idx about to wrap.
  assign w_commit = (state_q == OFF) && (cnt_q == CNT_W'(GAP - 1)) &&
                    (idx_q == IDX_W'(DIGITS - 1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    shown_d      = shown_q;
    pending_d    = pending_q;
    pend_flag_d  = pend_flag_q;
    frame_done_d = w_commit;

    if (load) begin
      pending_d   = in;
      pend_flag_d = 1'b1;
    end

    case (state_q)
      ON: begin
        if (cnt_q == CNT_W'(DIV - 1)) begin
          state_d = OFF;
          cnt_d   = '0;
        end
      end
      OFF: begin
        if (cnt_q == CNT_W'(GAP - 1)) begin
          state_d = ON;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
      end
      default: begin
        state_d = OFF;
        cnt_d   = '0;
      end
    endcase

    // A load landing on the commit edge bypasses the pending buffer.
    if (w_commit) begin
      if (load) begin
        shown_d = in;
      end else if (pend_flag_q) begin
        shown_d = pending_q;
      end
      pend_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= OFF;
      cnt_q        <= '0;
      idx_q        <= IDX_W'(DIGITS - 1);
      shown_q      <= '0;
      pending_q    <= '0;
      pend_flag_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shown_q      <= shown_d;
      pending_q    <= pending_d;
      pend_flag_q  <= pend_flag_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign w_nibble = shown_q[{idx_q, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .hex_i (w_nibble),
    .seg_o (w_dec)
  );

`ifdef SEVEN_SEG_LEADING_BLANK_EN
  logic [DIGITS-1:0] w_blank;

  // Digit k is blank when it and every more-significant nibble are zero.
  for (genvar k = 0; k < DIGITS; k++) begin : g_blank
    if (k == 0) begin : g_first
      assign w_blank[k] = 1'b0;
    end else begin : g_upper
      assign w_blank[k] = (shown_q[DIGITS*4-1:k*4] == '0);
    end
  end

  assign w_digit_blank = w_blank[idx_q];
`else
  assign w_digit_blank = 1'b0;
`endif

  always_comb begin
    an  = '1;
    seg = SEG_OFF;
    if (state_q == ON) begin
      an[idx_q] = 1'b0;
      seg       = w_digit_blank ? SEG_OFF : w_dec;
    end
  end

  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
// ============================================================================
// Module      : tb_seven_seg_scan
// Description : Directed self-checking bench for seven_seg_scan (4/4/2).
//               Honours SEVEN_SEG_LEADING_BLANK_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_seven_seg_scan;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
  localparam logic [6:0] S4 = 7'h19, S5 = 7'h12, SB = 7'h03, SC = 7'h46;
  localparam logic [6:0] SE = 7'h06, SF = 7'h0E, SX = 7'h7F;

`ifdef SEVEN_SEG_LEADING_BLANK_EN
  localparam logic [27:0] P_ZERO = {SX, SX, SX, S0};
  localparam logic [27:0] P_00C5 = {SX, SX, SC, S5};
`else
  localparam logic [27:0] P_ZERO = {S0, S0, S0, S0};
  localparam logic [27:0] P_00C5 = {S0, S0, SC, S5};
`endif
  localparam logic [27:0] P_1234 = {S1, S2, S3, S4};
  localparam logic [27:0] P_BEEF = {SB, SE, SE, SF};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] din = 16'h1234;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  seven_seg_scan #(.DIGITS(4), .DIV(4), .GAP(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (din),
    .load       (load),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Anode legality and blank-when-dark, every cycle.
  always @(negedge clk) begin
    chk("an_onehot", {31'd0, ($countones(~an) <= 1)}, 32'd1);
    if (an == 4'hF) chk("dark_seg", {25'd0, seg}, 32'h7F);
  end

  // Runs ncyc cycles of a frame starting at the negedge of digit 0's first
  // lit cycle; optional loads are driven after cycle l1 / l2 is checked.
  task automatic run_frame(input string nm, input logic [27:0] pats, input int ncyc,
                           input int l1, input logic [15:0] v1,
                           input int l2, input logic [15:0] v2);
    for (int c = 0; c < ncyc; c++) begin
      int d, t;
      d = c / 6;
      t = c % 6;
      if (t < 4) begin
        chk($sformatf("%s_an_c%0d", nm, c), {28'd0, an}, {28'd0, ~(4'b0001 << d)});
        chk($sformatf("%s_seg_c%0d", nm, c), {25'd0, seg}, {25'd0, pats[d*7 +: 7]});
      end else begin
        chk($sformatf("%s_gap_an_c%0d", nm, c), {28'd0, an}, 32'hF);
      end
      chk($sformatf("%s_fd_c%0d", nm, c), {31'd0, frame_done}, {31'd0, (c == 0)});
      load = (c == l1) || (c == l2);
      if (c == l1) din = v1;
      else if (c == l2) din = v2;
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  // Called at a negedge right after reset release; ends at first lit cycle.
  task automatic post_reset(input string nm);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_off_an%0d", nm, i), {28'd0, an}, 32'hF);
      chk($sformatf("%s_off_seg%0d", nm, i), {25'd0, seg}, 32'h7F);
      chk($sformatf("%s_off_fd%0d", nm, i), {31'd0, frame_done}, 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_an", {28'd0, an}, 32'hF);
      chk("rst_seg", {25'd0, seg}, 32'h7F);
      chk("rst_fd", {31'd0, frame_done}, 32'd0);
    end
    reset = 1'b0;
    post_reset("boot");

    run_frame("fA", P_ZERO, 24, 3, 16'h1234, -1, 16'h0);
    run_frame("fB", P_1234, 24, 5, 16'hAAAA, 15, 16'hBEEF);
    run_frame("fC", P_BEEF, 24, 23, 16'h00C5, -1, 16'h0);
    run_frame("fD", P_00C5, 24, -1, 16'h0, -1, 16'h0);
    run_frame("fE", P_00C5, 13, 1, 16'h9999, -1, 16'h0);

    chk("mid_an_digit2", {28'd0, an}, 32'hB);
    #2 reset = 1'b1;
    #1;
    chk("async_an", {28'd0, an}, 32'hF);
    chk("async_seg", {25'd0, seg}, 32'h7F);
    chk("async_fd", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    chk("hold_an", {28'd0, an}, 32'hF);
    @(negedge clk);
    reset = 1'b0;
    post_reset("rst2");

    run_frame("fF", P_ZERO, 24, -1, 16'h0, -1, 16'h0);
    run_frame("fG", P_ZERO, 24, -1, 16'h0, -1, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
